// File: rtl/slave_port.sv
// slave_port: responder end of the serial system bus.
// Deserialises addr/mode/write data, strobes one local memory, serialises reads.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   mode, wr_bus              mode (1=wr) with first bit, serial addr/data in
//   master_valid/slave_ready  wr-side bit handshake
//   slave_valid/master_ready  rd-side bit handshake, rd_bus data out
//   ack                       decoder acknowledge, checked on 6th addr bit
//   split                     read waiting on memory (SPLIT_EN=1)
//   s_addr, s_wr_data         local memory address / write data
//   s_wr_en, s_rd_en          one-cycle local strobes
//   s_rd_data, s_rd_valid     local read return
module slave_port #(
  parameter int ADDR_WIDTH   = 12,
  parameter bit SPLIT_EN     = 1'b0,
  parameter int ABORT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mode,
  input  logic                  wr_bus,
  output logic                  rd_bus,
  input  logic                  ack,
  input  logic                  master_valid,
  output logic                  slave_ready,
  input  logic                  master_ready,
  output logic                  slave_valid,
  output logic                  split,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [7:0]            s_wr_data,
  output logic                  s_wr_en,
  output logic                  s_rd_en,
  input  logic [7:0]            s_rd_data,
  input  logic                  s_rd_valid
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [7:0] GAP_LAST = 8'(ABORT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WR_DATA,
    ST_MEM_WR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_DATA
  } state_t;

  state_t          r_state, w_state_nx;
  logic            r_mode, w_mode_nx;
  logic [AW-2:0]   r_addr, w_addr_nx;
  logic [7:0]      r_data, w_data_nx;
  logic [3:0]      r_cnt, w_cnt_nx;
  logic [7:0]      r_gap, w_gap_nx;
  logic [AW-1:0]   r_saddr, w_saddr_nx;
  logic [7:0]      r_wdata, w_wdata_nx;
  logic            r_rdy, w_rdy_nx;

  logic [AW-1:0]   w_addr_sh;
  logic [7:0]      w_data_sh;
  logic            w_gap_hit;

  // Only the low AW address bits matter locally, so older bits fall off.
  assign w_addr_sh = {r_addr, wr_bus};
  assign w_data_sh = {r_data[6:0], wr_bus};
  assign w_gap_hit = (r_gap == GAP_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_mode  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_saddr <= '0;
      r_wdata <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_mode  <= w_mode_nx;
      r_addr  <= w_addr_nx;
      r_data  <= w_data_nx;
      r_cnt   <= w_cnt_nx;
      r_gap   <= w_gap_nx;
      r_saddr <= w_saddr_nx;
      r_wdata <= w_wdata_nx;
      r_rdy   <= w_rdy_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_mode_nx  = r_mode;
    w_addr_nx  = r_addr;
    w_data_nx  = r_data;
    w_cnt_nx   = r_cnt;
    w_gap_nx   = r_gap;
    w_saddr_nx = r_saddr;
    w_wdata_nx = r_wdata;
    unique case (r_state)
      ST_IDLE: begin
        w_gap_nx = '0;
        if (master_valid && r_rdy) begin
          w_mode_nx  = mode;
          w_addr_nx  = w_addr_sh[AW-2:0];
          w_cnt_nx   = 4'd1;
          w_state_nx = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (master_valid) begin
          w_gap_nx  = '0;
          w_addr_nx = w_addr_sh[AW-2:0];
          w_cnt_nx  = r_cnt + 4'd1;
          if (r_cnt == 4'd5 && !ack) begin
            w_cnt_nx   = '0;
            w_state_nx = ST_IDLE;
          end else if (r_cnt == 4'd15) begin
            w_cnt_nx   = '0;
            w_saddr_nx = w_addr_sh;
            w_state_nx = r_mode ? ST_WR_DATA : ST_RD_REQ;
          end
        end else if (w_gap_hit) begin
          w_gap_nx   = '0;
          w_cnt_nx   = '0;
          w_state_nx = ST_IDLE;
        end else begin
          w_gap_nx = r_gap + 8'd1;
        end
      end
      ST_WR_DATA: begin
        if (master_valid) begin
          w_gap_nx  = '0;
          w_data_nx = w_data_sh;
          w_cnt_nx  = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_cnt_nx   = '0;
            w_wdata_nx = w_data_sh;
            w_state_nx = ST_MEM_WR;
          end
        end else if (w_gap_hit) begin
          w_gap_nx   = '0;
          w_cnt_nx   = '0;
          w_state_nx = ST_IDLE;
        end else begin
          w_gap_nx = r_gap + 8'd1;
        end
      end
      ST_MEM_WR:  w_state_nx = ST_IDLE;
      ST_RD_REQ:  w_state_nx = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (s_rd_valid) begin
          w_data_nx  = s_rd_data;
          w_cnt_nx   = '0;
          w_state_nx = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (master_ready) begin
          w_data_nx = {r_data[6:0], 1'b0};
          w_cnt_nx  = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_cnt_nx   = '0;
            w_state_nx = ST_IDLE;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    // Registered so ready is 0 during reset yet tracks the state after.
    w_rdy_nx = (w_state_nx == ST_IDLE) ||
               (w_state_nx == ST_ADDR) ||
               (w_state_nx == ST_WR_DATA);
  end

  assign slave_ready = r_rdy;
  assign slave_valid = (r_state == ST_RD_DATA);
  assign rd_bus      = slave_valid & r_data[7];
  assign split       = SPLIT_EN &
                       ((r_state == ST_RD_REQ) ||
                        (r_state == ST_RD_WAIT));
  assign s_wr_en     = (r_state == ST_MEM_WR);
  assign s_rd_en     = (r_state == ST_RD_REQ);
  assign s_addr      = r_saddr;
  assign s_wr_data   = r_wdata;

endmodule
